// File: rtl/kdw_ram_ctrl_if.sv
// Bundle between the depthwise weight-RAM sequencer and its clients: DMA load
// stream, PE fetch port and the single-port weight RAM.
interface kdw_ram_ctrl_if #(
  parameter int WG_W = 8,
  parameter int K_SZ = 9,
  parameter int N_CH = 32,
  localparam int KDW_N_ELEM = K_SZ * N_CH,
  localparam int AW = $clog2(KDW_N_ELEM),
  localparam int CW = $clog2(N_CH)
);
  logic            ld_start;
  logic [AW:0]     ld_nelem;
  logic            ld_valid;
  logic [WG_W-1:0] ld_data;
  logic            ld_ready;
  logic            ld_done;
  logic            rd_start;
  logic [CW-1:0]   rd_ch;
  logic            w_valid;
  logic [WG_W-1:0] w_data;
  logic [3:0]      w_idx;
  logic            rd_done;
  logic            busy;
  logic            err;
  logic [AW-1:0]   ram_addr;
  logic [WG_W-1:0] ram_data;
  logic            ram_write;
  logic [WG_W-1:0] ram_res;

  modport slave (
    input  ld_start, ld_nelem, ld_valid, ld_data, rd_start, rd_ch, ram_res,
    output ld_ready, ld_done, w_valid, w_data, w_idx, rd_done, busy, err,
           ram_addr, ram_data, ram_write
  );

  modport master (
    output ld_start, ld_nelem, ld_valid, ld_data, rd_start, rd_ch, ram_res,
    input  ld_ready, ld_done, w_valid, w_data, w_idx, rd_done, busy, err,
           ram_addr, ram_data, ram_write
  );
endinterface

// File: rtl/kdw_ram_ctrl.sv
// Depthwise-kernel weight RAM sequencer: serialises DMA loads and per-channel
// K_SZ-weight kernel fetches onto one single-port synchronous RAM.
module kdw_ram_ctrl #(
  parameter int WG_W = 8,
  parameter int K_SZ = 9,
  parameter int N_CH = 32,
  localparam int KDW_N_ELEM = K_SZ * N_CH,
  localparam int AW = $clog2(KDW_N_ELEM),
  localparam int CW = $clog2(N_CH)
) (
  input logic           clk,
  input logic           rst_n,
  kdw_ram_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, LDFIN, READ, RDDRAIN} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     nelem_q, nelem_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW-1:0]   base_q, base_d;
  logic [3:0]      i_q, i_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [WG_W-1:0] ram_data_q, ram_data_d;
  logic            ram_write_q, ram_write_d;
  logic            rd_vld_p1_q, rd_vld_p1_d;
  logic [3:0]      rd_idx_p1_q, rd_idx_p1_d;
  logic            w_valid_q, w_valid_d;
  logic [3:0]      w_idx_q, w_idx_d;
  logic            ld_done_q, ld_done_d;
  logic            rd_done_q, rd_done_d;
  logic            err_q, err_d;

  logic [CW-1:0]   rd_ch;
  logic            ch_ok;
  logic [AW-1:0]   rd_base;

  assign rd_ch   = bus.rd_ch;
  assign ch_ok   = 32'(rd_ch) < 32'(N_CH);
  assign rd_base = AW'(rd_ch) * AW'(K_SZ);

  always_comb begin
    state_d     = state_q;
    nelem_d     = nelem_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    i_d         = i_q;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_write_d = 1'b0;
    rd_vld_p1_d = 1'b0;
    rd_idx_p1_d = '0;
    ld_done_d   = 1'b0;
    err_d       = 1'b0;
    // p1 -> output: the RAM answers one cycle after the address was issued
    w_valid_d   = rd_vld_p1_q;
    w_idx_d     = rd_vld_p1_q ? rd_idx_p1_q : '0;
    rd_done_d   = rd_vld_p1_q && (rd_idx_p1_q == 4'(K_SZ - 1));

    case (state_q)
      IDLE: begin
        if (bus.ld_start) begin
          if (bus.ld_nelem > (AW+1)'(KDW_N_ELEM)) begin
            err_d = 1'b1;
          end else if (bus.ld_nelem == '0) begin
            ld_done_d = 1'b1;
          end else begin
            nelem_d = bus.ld_nelem;
            cnt_d   = '0;
            state_d = LOAD;
          end
        end else if (bus.rd_start) begin
          if (!ch_ok) begin
            err_d = 1'b1;
          end else begin
            // first address goes out with the state change so word 0 is on the bus in cycle 1
            base_d      = rd_base;
            ram_addr_d  = rd_base;
            rd_vld_p1_d = 1'b1;
            rd_idx_p1_d = '0;
            i_d         = 4'd1;
            state_d     = READ;
          end
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          ram_addr_d  = cnt_q[AW-1:0];
          ram_data_d  = bus.ld_data;
          ram_write_d = 1'b1;
          cnt_d       = cnt_q + (AW+1)'(1);
          if (cnt_q == nelem_q - (AW+1)'(1)) begin
            ld_done_d = 1'b1;
            state_d   = LDFIN;
          end
        end
      end
      LDFIN: begin
        state_d = IDLE;
      end
      READ: begin
        ram_addr_d  = base_q + AW'(i_q);
        rd_vld_p1_d = 1'b1;
        rd_idx_p1_d = i_q;
        i_d         = i_q + 4'd1;
        if (i_q == 4'(K_SZ - 1)) begin
          state_d = RDDRAIN;
        end
      end
      RDDRAIN: begin
        if (rd_done_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nelem_q     <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      i_q         <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_write_q <= 1'b0;
      rd_vld_p1_q <= 1'b0;
      rd_idx_p1_q <= '0;
      w_valid_q   <= 1'b0;
      w_idx_q     <= '0;
      ld_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nelem_q     <= nelem_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      i_q         <= i_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_write_q <= ram_write_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      rd_idx_p1_q <= rd_idx_p1_d;
      w_valid_q   <= w_valid_d;
      w_idx_q     <= w_idx_d;
      ld_done_q   <= ld_done_d;
      rd_done_q   <= rd_done_d;
      err_q       <= err_d;
    end
  end

  // ram_res is already the RAM's output register; gating keeps w_data at 0 off-beat and in reset
  assign bus.w_data    = w_valid_q ? bus.ram_res : '0;
  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.ld_done   = ld_done_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.w_idx     = w_idx_q;
  assign bus.rd_done   = rd_done_q;
  assign bus.err       = err_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_write = ram_write_q;

endmodule

// File: tb/tb_kdw_ram_ctrl.sv
// Randomised bench for kdw_ram_ctrl: a behavioural RAM plus a shadow array of
// what every load should have stored; fetches are checked against that array.
module tb_kdw_ram_ctrl;
  localparam int WG_W = 8;
  localparam int K_SZ = 9;
  localparam int N_CH = 32;
  localparam int NE   = K_SZ * N_CH;
  localparam int AW   = $clog2(NE);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kdw_ram_ctrl_if #(.WG_W(WG_W), .K_SZ(K_SZ), .N_CH(N_CH)) bus();

  kdw_ram_ctrl #(.WG_W(WG_W), .K_SZ(K_SZ), .N_CH(N_CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // single-port RAM: registered read, write-through
  logic [WG_W-1:0] mem [0:511];
  always @(posedge clk) begin
    if (bus.ram_write) begin
      mem[bus.ram_addr] <= bus.ram_data;
      bus.ram_res       <= bus.ram_data;
    end else begin
      bus.ram_res <= mem[bus.ram_addr];
    end
  end

  int ref_mem [0:NE-1];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // monitor, sampled on the falling edge
  int wr_addr_q[$];
  int wr_data_q[$];
  int rd_idx_q[$];
  int rd_dat_q[$];
  int rd_cyc_q[$];
  int last_wr_cyc, ld_done_cyc, rd_done_cyc;
  int n_ld_done, n_rd_done, n_errp;
  int addr_log [0:63];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_write) begin
        wr_addr_q.push_back(int'(bus.ram_addr));
        wr_data_q.push_back(int'(bus.ram_data));
        last_wr_cyc = cyc;
      end
      if (bus.w_valid) begin
        rd_idx_q.push_back(int'(bus.w_idx));
        rd_dat_q.push_back(int'(bus.w_data));
        rd_cyc_q.push_back(cyc);
      end
      if (bus.ld_done) begin
        n_ld_done++;
        ld_done_cyc = cyc;
      end
      if (bus.rd_done) begin
        n_rd_done++;
        rd_done_cyc = cyc;
      end
      if (bus.err) n_errp++;
      addr_log[cyc % 64] = int'(bus.ram_addr);
    end
  end

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_idx_q.delete();
    rd_dat_q.delete();
    rd_cyc_q.delete();
    n_ld_done = 0;
    n_rd_done = 0;
    n_errp = 0;
    last_wr_cyc = -1;
    ld_done_cyc = -2;
    rd_done_cyc = -1;
  endtask

  function automatic logic [63:0] outs();
    return {28'd0, bus.ld_ready, bus.ld_done, bus.w_valid, bus.w_data, bus.w_idx,
            bus.rd_done, bus.busy, bus.err, bus.ram_addr, bus.ram_data, bus.ram_write};
  endfunction

  // vmode: 0 valid held high, 1 random valid, 2 fixed stall pattern
  task automatic do_load(int nelem, int vmode, int dbase, bit with_rd);
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int exp_data[$];
    int k = 0;
    int step = 0;
    int guard = 0;
    int v;
    clear_mon();
    bus.ld_nelem = (AW+1)'(nelem);
    bus.ld_start = 1'b1;
    if (with_rd) begin
      bus.rd_start = 1'b1;
      bus.rd_ch    = 5'($urandom_range(0, N_CH - 1));
    end
    tick();
    bus.ld_start = 1'b0;
    bus.rd_start = 1'b0;
    check_val("ld_busy", bus.busy, 1);
    if (with_rd) check_val("ld_wins_ready", bus.ld_ready, 1);
    while (k < nelem && guard < 5000) begin
      case (vmode)
        0:       v = 1;
        1:       v = int'($urandom_range(0, 1));
        default: v = pat[step % 7];
      endcase
      bus.ld_valid = v[0];
      bus.ld_data  = (dbase >= 0) ? WG_W'(dbase + k) : WG_W'($urandom);
      if (with_rd) bus.rd_start = 1'($urandom_range(0, 1));
      if (v != 0 && bus.ld_ready) begin
        ref_mem[k] = int'(bus.ld_data);
        exp_data.push_back(int'(bus.ld_data));
        k++;
      end
      tick();
      step++;
      guard++;
    end
    bus.ld_valid = 1'b0;
    bus.rd_start = 1'b0;
    if (k < nelem) check_val("ld_timeout", k, nelem);
    guard = 0;
    while (bus.busy && guard < 10) begin
      tick();
      guard++;
    end
    check_val("ld_idle", bus.busy, 0);
    check_val("ld_nwrites", wr_addr_q.size(), nelem);
    for (int i = 0; i < nelem && i < wr_addr_q.size(); i++) begin
      check_val("ld_addr", wr_addr_q[i], i);
      check_val("ld_data", wr_data_q[i], exp_data[i]);
    end
    check_val("ld_done_cnt", n_ld_done, 1);
    check_val("ld_done_cyc", ld_done_cyc, last_wr_cyc);
    check_val("ld_no_wvalid", rd_idx_q.size(), 0);
  endtask

  task automatic do_fetch(int ch, bit rst_mid);
    int c0;
    int guard = 0;
    clear_mon();
    bus.rd_start = 1'b1;
    bus.rd_ch    = 5'(ch);
    c0 = cyc;
    tick();
    bus.rd_start = 1'b0;
    if (rst_mid) begin
      while (cyc < c0 + 5) tick();
      rst_n = 1'b0;
      #1;
      check_val("rst_async_outs", outs(), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      check_val("rst_idle", bus.busy, 0);
      check_val("rst_no_rd_done", n_rd_done, 0);
      return;
    end
    while (bus.busy && guard < 40) begin
      tick();
      guard++;
    end
    check_val("rd_idle_cyc", cyc - c0, K_SZ + 2);
    check_val("rd_nbeats", rd_idx_q.size(), K_SZ);
    for (int i = 0; i < K_SZ && i < rd_idx_q.size(); i++) begin
      check_val("rd_idx", rd_idx_q[i], i);
      check_val("rd_data", rd_dat_q[i], ref_mem[ch * K_SZ + i]);
      check_val("rd_beat_cyc", rd_cyc_q[i] - c0, 2 + i);
      check_val("rd_addr", addr_log[(c0 + 1 + i) % 64], ch * K_SZ + i);
    end
    check_val("rd_done_cnt", n_rd_done, 1);
    check_val("rd_done_cyc", rd_done_cyc - c0, K_SZ + 1);
    check_val("rd_no_err", n_errp, 0);
  endtask

  task automatic do_bad_ld(int nelem);
    clear_mon();
    bus.ld_nelem = (AW+1)'(nelem);
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    check_val("bad_busy", bus.busy, 0);
    tick();
    tick();
    check_val("bad_nwrites", wr_addr_q.size(), 0);
    if (nelem > NE) begin
      check_val("bad_err", n_errp, 1);
      check_val("bad_no_done", n_ld_done, 0);
    end else begin
      check_val("zero_done", n_ld_done, 1);
      check_val("zero_no_err", n_errp, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int i = 0; i < NE; i++) ref_mem[i] = 0;
    bus.ld_start = 1'b0;
    bus.ld_nelem = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.rd_start = 1'b0;
    bus.rd_ch    = '0;
    clear_mon();
    rst_n = 1'b0;
    repeat (3) tick();
    check_val("reset_outs", outs(), 0);
    rst_n = 1'b1;
    tick();
    check_val("post_reset_outs", outs(), 0);

    do_load(18, 0, 'h10, 1'b0);
    do_fetch(1, 1'b0);

    do_load(4, 2, -1, 1'b0);
    do_fetch(0, 1'b0);

    do_load(7, 1, -1, 1'b1);

    do_bad_ld(NE + 1);
    do_bad_ld(int'($urandom_range(NE + 2, 1023)));
    do_bad_ld(0);

    do_load(NE, 1, -1, 1'b0);
    do_fetch(N_CH - 1, 1'b0);
    do_fetch(0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      do_load(int'($urandom_range(1, 60)), 1, -1, 1'b0);
      do_fetch(int'($urandom_range(0, N_CH - 1)), 1'b0);
    end

    do_fetch(13, 1'b1);
    do_fetch(13, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kdw_ram_ctrl.md
Name: kdw_ram_ctrl

Overview:
- Sequencer for the depthwise-kernel weight RAM, a single-port synchronous RAM with one-cycle registered read and write-through.
- Owns the RAM port and drives it from two clients:
  - the DMA load stream, which fills the RAM with weights;
  - the depthwise PE, which fetches one channel's K_SZ-weight kernel.
- Serialises load and fetch operations, generates addresses, and flags out-of-range requests.

Parameters:
- WG_W, 8, weight word width in bits
- K_SZ, 9, weights per channel kernel (3x3)
- N_CH, 32, max channels held
- KDW_N_ELEM, K_SZ*N_CH (288), RAM depth in words
- AW, $clog2(KDW_N_ELEM), RAM address width
- CW, $clog2(N_CH), channel index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ld_start  in  1  start load, sampled in IDLE
- ld_nelem  in  AW+1  number of words to load, sampled with ld_start
- ld_valid  in  1  DMA word valid
- ld_data  in  WG_W  DMA word
- ld_ready  out  1  controller accepts ld_data
- ld_done  out  1  one-cycle pulse, load complete
- rd_start  in  1  start kernel fetch, sampled in IDLE
- rd_ch  in  CW  channel to fetch, sampled with rd_start
- w_valid  out  1  weight valid to PE
- w_data  out  WG_W  weight to PE
- w_idx  out  4  position of weight in kernel, 0..K_SZ-1
- rd_done  out  1  one-cycle pulse with the last w_valid
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse, request rejected
- ram_addr  out  AW  RAM address
- ram_data  out  WG_W  RAM write data
- ram_write  out  1  RAM write enable
- ram_res  in  WG_W  RAM read data, valid one cycle after address

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-operation aborts the operation immediately:
  - no ld_done or rd_done is issued;
  - RAM contents are not touched by the controller after reset.
- ram_addr, ram_data, ram_write, w_valid, w_data, w_idx, ld_done, rd_done and err are registered.
- States: IDLE, LOAD, LDFIN, READ, RDDRAIN.
- IDLE:
  - ld_start and rd_start in the same cycle: load wins, the read request is dropped.
  - ld_start with ld_nelem > KDW_N_ELEM: err pulse next cycle, stay IDLE.
  - ld_start with ld_nelem == 0: ld_done pulse next cycle, no writes, stay IDLE.
  - Otherwise ld_start latches nelem, clears cnt, and moves to LOAD.
  - rd_start with rd_ch >= N_CH: err pulse, stay IDLE.
  - Otherwise rd_start sets base = rd_ch*K_SZ and moves to READ.
  - ram_write is 0 in IDLE.
- LOAD:
  - ld_ready = 1 (combinational from state).
  - Each cycle with ld_valid && ld_ready is a beat: next cycle ram_addr = cnt, ram_data = ld_data, ram_write = 1, then cnt++.
  - Cycles without ld_valid: ram_write = 0 next cycle, cnt held (stall).
  - Beat with cnt == nelem-1 moves to LDFIN; ld_ready drops the following cycle.
- LDFIN (one cycle): the last write is on the RAM port, ld_done = 1, then IDLE.
- READ:
  - Issues ram_addr = base+i, ram_write = 0, for i = 0..K_SZ-1 on consecutive cycles, no gaps.
  - After i = K_SZ-1, moves to RDDRAIN.
- Fetch output:
  - w_valid, w_data = ram_res and w_idx = i follow each address by one cycle.
  - rd_done is asserted with the w_idx = K_SZ-1 beat.
  - In RDDRAIN, return to IDLE on that beat.
- Fetch latency: rd_start at cycle 0 → ram_addr = base at cycle 1 → w_idx = 0 at cycle 2 → last beat and rd_done at cycle K_SZ+1 → IDLE at cycle K_SZ+2.
- ld_start and rd_start while busy are ignored (no err, no queueing).
- The PE has no back-pressure; it must accept every w_valid beat.
- Arithmetic:
  - base uses an AW-bit product.
  - rd_ch < N_CH guarantees base+K_SZ-1 <= KDW_N_ELEM-1, so addresses never wrap.
  - cnt is AW+1 bits wide.

Test Plan:
- Load then fetch: ld_start, nelem = 18, words 0x10..0x21 with ld_valid held high → 18 writes at addr 0..17, ld_done one cycle after the last beat; then rd_ch = 1 → w_idx 0..8 carry 0x19..0x21 on cycles 2..10, rd_done on cycle 10.
- Stalled load: nelem = 4, ld_valid toggling 1,0,0,1,1,0,1 → exactly 4 writes at addr 0..3 with correct data, no write in stall cycles, one ld_done.
- Simultaneous start in IDLE: ld_start and rd_start together → LOAD entered, no w_valid ever, rd_start asserted during LOAD ignored.
- Range errors:
  - ld_nelem = 289 → err pulse, busy stays 0, no ram_write.
  - rd_ch = 32 (CW = 5 so representable only as 32 when N_CH < 2^CW; with the default N_CH = 32, use nelem = 0 instead) → ld_done pulse, no writes.
- Full-depth boundary: load 288 words, fetch rd_ch = 31 → ram_addr 279..287, data correct, no wrap to 0.
- Reset mid-fetch: rst_n low at cycle 5 of a fetch → all outputs 0 asynchronously, no rd_done; a new fetch after reset returns correct weights.
